digest_tx: RTL and testbench

DIGEST_TX -- requirements
Module: digest_tx

---
 rtl/digest_tx.sv | 125 ++++++++++++
 tb/tb_digest_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/digest_tx.sv
// Serialises a captured 160-bit SHA-1 digest to a byte-wide transmitter, as ASCII hex + CR LF or as raw bytes.
// Latency: start at cycle N -> first byte valid at N+1; with no stalls spart_done at N+NBYTES+1.
// Backpressure: a byte moves only when tx_valid && tx_rdy; tx_data and the byte counter hold while tx_rdy is low.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, hh         one-cycle transmit request and the 160-bit digest sampled with it (H0 in [159:128])
//   tx_rdy            transmitter accepts a byte this cycle
//   tx_data, tx_valid byte to the transmitter and its qualifier
//   busy, spart_done  transmission in progress; one-cycle pulse after the final byte
module digest_tx #(
    parameter int ASCII_HEX = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [159:0] hh,
    input  logic         tx_rdy,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    output logic         busy,
    output logic         spart_done
);

    localparam int         NBYTES = (ASCII_HEX != 0) ? 42 : 20;
    localparam logic [5:0] LAST   = 6'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [5:0]     cnt;
    logic [159:0]   dig;
    logic           xfer;
    logic           last;

    // Byte k of the outgoing stream for digest d.
    function automatic logic [7:0] byte_at(input logic [159:0] d, input logic [5:0] k);
        logic [159:0] sh;
        logic [3:0]   nib;
        logic [7:0]   b;
        b   = 8'h00;
        sh  = '0;
        nib = 4'h0;
        if (ASCII_HEX != 0) begin
            // Shift the wanted nibble to the top; k >= 40 shifts everything out, which is harmless.
            sh  = d << {k, 2'b00};
            nib = sh[159:156];
            if (k == 6'd40)
                b = 8'h0D;
            else if (k == 6'd41)
                b = 8'h0A;
            else if (nib < 4'd10)
                b = 8'h30 + {4'h0, nib};
            else
                b = 8'h57 + {4'h0, nib};   // 0x57 + 10 = 'a'
        end else begin
            sh = d << {k, 3'b000};
            b  = sh[159:152];
        end
        return b;
    endfunction

    assign xfer = (state == SEND) && tx_rdy;
    assign last = (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE, so requests during SEND/DONE are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (xfer && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        tx_valid   = 1'b0;
        busy       = 1'b0;
        spart_done = 1'b0;
        case (state)
            SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                spart_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: tx_data is preloaded one byte ahead so it is purely registered and
    // keeps the last byte sent once the FSM is back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 6'd0;
            dig     <= '0;
            tx_data <= 8'h00;
        end else if (state == IDLE && start) begin
            dig     <= hh;
            cnt     <= 6'd0;
            tx_data <= byte_at(hh, 6'd0);
        end else if (xfer && !last) begin
            cnt     <= cnt + 6'd1;
            tx_data <= byte_at(dig, cnt + 6'd1);
        end
    end

endmodule

// File: tb/tb_digest_tx.sv
// Directed bench for digest_tx: one ASCII-mode and one raw-mode instance share clock, reset, digest and tx_rdy.
module tb_digest_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a;
    logic         start_r;
    logic [159:0] hh;
    logic         tx_rdy;
    logic [7:0]   data_a, data_r;
    logic         valid_a, valid_r, busy_a, busy_r, done_a, done_r;

    int total = 0;
    int bad   = 0;

    localparam logic [159:0] HH_REF  = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] HH_ONES = {160{1'b1}};

    digest_tx #(.ASCII_HEX(1)) u_ascii (
        .clk(clk), .rst(rst), .start(start_a), .hh(hh), .tx_rdy(tx_rdy),
        .tx_data(data_a), .tx_valid(valid_a), .busy(busy_a), .spart_done(done_a)
    );

    digest_tx #(.ASCII_HEX(0)) u_raw (
        .clk(clk), .rst(rst), .start(start_r), .hh(hh), .tx_rdy(tx_rdy),
        .tx_data(data_r), .tx_valid(valid_r), .busy(busy_r), .spart_done(done_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Per-run observations
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int first_v, last_x, done_c, idle_c, n_done, stall_bad;
    logic v_end;

    function automatic logic rdy_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return (((c - 1) % 4) == 0) || (((c - 1) % 4) == 3);   // 1,0,0,1 from cycle 1
    endfunction

    task automatic set_exp_ascii(input string s);
        exp_q.delete();
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic int seq_err();
        int e = 0;
        if (got.size() != exp_q.size()) e++;
        for (int k = 0; k < got.size() && k < exp_q.size(); k++)
            if (got[k] !== exp_q[k]) e++;
        return e;
    endfunction

    // Call at a negedge: start is raised in the current cycle (cycle 0).
    // hook: 0 none, 1 new hh + start at byte 10, 2 reset at byte 15, 3 start during DONE.
    task automatic run(input bit raw, input int mode, input int hook, input int maxc);
        logic [7:0] prev;
        logic       pv, v, dn, b;
        logic [7:0] d;
        bit         fired;
        got.delete();
        first_v = -1; last_x = -1; done_c = -1; idle_c = -1;
        n_done = 0; stall_bad = 0; v_end = 1'b1;
        pv = 1'b0; prev = 8'h00; fired = 1'b0;
        if (raw) start_r = 1'b1; else start_a = 1'b1;
        tx_rdy = rdy_at(mode, 0);
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_r = 1'b0;
            rst     = 1'b0;
            tx_rdy  = rdy_at(mode, c);
            v  = raw ? valid_r : valid_a;
            d  = raw ? data_r  : data_a;
            dn = raw ? done_r  : done_a;
            b  = raw ? busy_r  : busy_a;
            if (v && first_v < 0) first_v = c;
            if (pv && v && d !== prev) stall_bad++;
            pv   = v && !tx_rdy;
            prev = d;
            if (v && tx_rdy) begin
                got.push_back(d);
                last_x = c;
            end
            if (dn) begin
                n_done++;
                done_c = c;
            end
            if (!b && c > 1) begin
                idle_c = c;
                v_end  = v;
                break;
            end
            if (!fired && hook == 1 && got.size() == 10) begin
                fired   = 1'b1;
                hh      = HH_ONES;
                start_a = 1'b1;
            end
            if (!fired && hook == 2 && got.size() == 15) begin
                fired = 1'b1;
                rst   = 1'b1;
            end
            if (!fired && hook == 3 && dn) begin
                fired   = 1'b1;
                start_a = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_r = 1'b0; tx_rdy = 1'b0; hh = HH_REF;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_done",  {31'd0, done_a},  32'd0);
        check("rst_data",  {24'd0, data_a},  32'd0);
        check("rst_data_raw", {24'd0, data_r}, 32'd0);
        // start together with reset must be ignored
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("start_in_rst", {31'd0, busy_a}, 32'd0);

        // ASCII, no stalls; start during DONE must be dropped
        set_exp_ascii("a9993e364706816aba3e25717850c26c9cd0d89d");
        run(1'b0, 0, 3, 60);
        check("asc_count",  got.size(), 32'd42);
        check("asc_byte0",  {24'd0, got[0]}, 32'h61);
        check("asc_byte1",  {24'd0, got[1]}, 32'h39);
        check("asc_seq",    seq_err(), 32'd0);
        check("asc_first",  first_v, 32'd1);
        check("asc_lastx",  last_x,  32'd42);
        check("asc_donec",  done_c,  32'd43);
        check("asc_idlec",  idle_c,  32'd44);
        check("asc_ndone",  n_done,  32'd1);
        check("asc_hold",   {24'd0, data_a}, 32'h0A);

        // Back-to-back: start in the first idle cycle after spart_done
        run(1'b0, 0, 0, 60);
        check("b2b_first", first_v, 32'd1);
        check("b2b_seq",   seq_err(), 32'd0);
        check("b2b_donec", done_c, 32'd43);

        // Raw mode
        exp_q = '{8'ha9, 8'h99, 8'h3e, 8'h36, 8'h47, 8'h06, 8'h81, 8'h6a, 8'hba, 8'h3e,
                  8'h25, 8'h71, 8'h78, 8'h50, 8'hc2, 8'h6c, 8'h9c, 8'hd0, 8'hd8, 8'h9d};
        run(1'b1, 0, 0, 40);
        check("raw_count", got.size(), 32'd20);
        check("raw_seq",   seq_err(), 32'd0);
        check("raw_lastx", last_x, 32'd20);
        check("raw_donec", done_c, 32'd21);
        check("raw_idlec", idle_c, 32'd22);

        // ASCII with tx_rdy 1,0,0,1 stalls
        set_exp_ascii("a9993e364706816aba3e25717850c26c9cd0d89d");
        run(1'b0, 1, 0, 200);
        check("stl_count", got.size(), 32'd42);
        check("stl_seq",   seq_err(), 32'd0);
        check("stl_hold",  stall_bad, 32'd0);
        check("stl_ndone", n_done, 32'd1);

        // hh changed and start re-pulsed mid-transmission
        run(1'b0, 0, 1, 60);
        check("cap_seq",   seq_err(), 32'd0);
        check("cap_ndone", n_done, 32'd1);
        check("cap_idlec", idle_c, 32'd44);

        // Reset at byte 15, then all-ones digest
        hh = HH_REF;
        run(1'b0, 0, 2, 60);
        check("abort_valid", {31'd0, v_end}, 32'd0);
        check("abort_ndone", n_done, 32'd0);
        check("abort_count", got.size(), 32'd15);
        check("abort_data",  {24'd0, data_a}, 32'd0);
        hh = HH_ONES;
        set_exp_ascii("ffffffffffffffffffffffffffffffffffffffff");
        run(1'b0, 0, 0, 60);
        check("ones_seq",   seq_err(), 32'd0);
        check("ones_ndone", n_done, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
